// File: rtl/seq_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mul_div_unit
//  Purpose  : Iterative signed MUL/MULH/DIV/REM unit; shift-add multiplier and
//             restoring divider share one magnitude datapath, one op in flight.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_mul_div_unit #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [WIDTH-1:0]      rsData,
    input  logic [WIDTH-1:0]      rtData,
    input  logic [REG_ADDR_W-1:0] rdIn,
    output logic                  busy,
    output logic                  done,
    output logic                  regWrite,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [WIDTH-1:0]      writeData
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [1:0]       OP_MUL   = 2'b00;
    localparam logic [1:0]       OP_MULH  = 2'b01;
    localparam logic [1:0]       OP_DIV   = 2'b10;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [1:0]              op_q;
    logic                    sign_a_q;
    logic                    sign_b_q;
    logic                    div_zero_q;
    // hi_q: product high word / partial remainder
    // lo_q: multiplier being consumed / dividend shifting out, quotient shifting in
    // b_q : multiplicand / divisor magnitude
    logic [WIDTH-1:0]        hi_q;
    logic [WIDTH-1:0]        lo_q;
    logic [WIDTH-1:0]        b_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    regwrite_q;
    logic [REG_ADDR_W-1:0]   rd_q;
    logic [WIDTH-1:0]        wdata_q;

    logic [WIDTH-1:0]        abs_a_d;
    logic [WIDTH-1:0]        abs_b_d;
    logic [WIDTH:0]          mul_sum_d;
    logic [WIDTH:0]          div_shift_d;
    logic [WIDTH:0]          div_diff_d;
    logic                    div_ge_d;
    logic [2*WIDTH-1:0]      prod_d;
    logic [WIDTH-1:0]        quo_d;
    logic [WIDTH-1:0]        rem_d;
    logic [WIDTH-1:0]        result_d;

    // Two's-complement negation leaves MIN as 0x80..0, which is its correct magnitude.
    always_comb begin
        abs_a_d = rsData[WIDTH-1] ? -rsData : rsData;
        abs_b_d = rtData[WIDTH-1] ? -rtData : rtData;
    end

    always_comb begin
        mul_sum_d   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        div_shift_d = {hi_q, lo_q[WIDTH-1]};
        div_diff_d  = div_shift_d - {1'b0, b_q};
        div_ge_d    = (div_shift_d >= {1'b0, b_q});
    end

    always_comb begin
        prod_d = (sign_a_q ^ sign_b_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo_d  = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
        rem_d  = sign_a_q ? -hi_q : hi_q;
        case (op_q)
            OP_MUL:  result_d = prod_d[WIDTH-1:0];
            OP_MULH: result_d = prod_d[2*WIDTH-1:WIDTH];
            OP_DIV:  result_d = div_zero_q ? {WIDTH{1'b1}} : quo_d;
            default: result_d = rem_d;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            b_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
        end else begin
            done_q     <= 1'b0;
            regwrite_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_CALC;
                        cnt_q      <= '0;
                        op_q       <= op;
                        rd_q       <= rdIn;
                        sign_a_q   <= rsData[WIDTH-1];
                        sign_b_q   <= rtData[WIDTH-1];
                        div_zero_q <= (rtData == '0);
                        hi_q       <= '0;
                        if (op[1]) begin
                            lo_q <= abs_a_d;
                            b_q  <= abs_b_d;
                        end else begin
                            lo_q <= abs_b_d;
                            b_q  <= abs_a_d;
                        end
                    end
                end
                ST_CALC: begin
                    busy_q <= 1'b1;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (op_q[1]) begin
                        hi_q <= div_ge_d ? div_diff_d[WIDTH-1:0] : div_shift_d[WIDTH-1:0];
                        lo_q <= {lo_q[WIDTH-2:0], div_ge_d};
                    end else begin
                        hi_q <= mul_sum_d[WIDTH:1];
                        lo_q <= {mul_sum_d[0], lo_q[WIDTH-1:1]};
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    wdata_q    <= result_d;
                    done_q     <= 1'b1;
                    regwrite_q <= (rd_q != '0);
                    state_q    <= ST_DONE;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign regWrite  = regwrite_q;
    assign rd        = rd_q;
    assign writeData = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_mul_div_unit
//  Purpose  : Directed-vector scoreboard bench for seq_mul_div_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mul_div_unit;

    localparam int WIDTH = 32;
    localparam int RAW   = 5;

    logic             clk;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rsData;
    logic [WIDTH-1:0] rtData;
    logic [RAW-1:0]   rdIn;
    logic             busy;
    logic             done;
    logic             regWrite;
    logic [RAW-1:0]   rd;
    logic [WIDTH-1:0] writeData;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [RAW-1:0]   rd;
        logic             we;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    seq_mul_div_unit #(.WIDTH(WIDTH), .REG_ADDR_W(RAW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .rsData    (rsData),
        .rtData    (rtData),
        .rdIn      (rdIn),
        .busy      (busy),
        .done      (done),
        .regWrite  (regWrite),
        .rd        (rd),
        .writeData (writeData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst === 1'b1 && (done !== 1'b0 || regWrite !== 1'b0)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: done=%b regWrite=%b rd=%0d at cycle %0d",
                         done, regWrite, rd, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("writeData", 64'(writeData), 64'(e.data));
                chk("rd", 64'(rd), 64'(e.rd));
                chk("regWrite", 64'(regWrite), 64'(e.we));
                chk("done", 64'(done), 64'd1);
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [RAW-1:0] r,
                         input logic [WIDTH-1:0] exp_data);
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rsData = a;
        rtData = b;
        rdIn   = r;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op     = 2'($urandom);
        rsData = $urandom;
        rtData = $urandom;
        rdIn   = 5'($urandom);
        e.data = exp_data;
        e.rd   = r;
        e.we   = (r != 0);
        e.cyc  = cyc + WIDTH + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        chk("busy_after_accept", 64'(busy), 64'd1);
    endtask

    task automatic drain(input logic [WIDTH-1:0] exp_data);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL completion_timeout: %0d outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
        chk("busy_idle", 64'(busy), 64'd0);
        chk("writeData_held", 64'(writeData), 64'(exp_data));
    endtask

    task automatic run(input logic [1:0] o, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [RAW-1:0] r,
                       input logic [WIDTH-1:0] exp_data);
        issue(o, a, b, r, exp_data);
        drain(exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        rsData = '0;
        rtData = '0;
        rdIn   = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_regWrite", 64'(regWrite), 64'd0);
        chk("reset_rd", 64'(rd), 64'd0);
        chk("reset_writeData", 64'(writeData), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run(2'b00, 32'd7,         32'hFFFFFFFA, 5'd5,  32'hFFFFFFD6);
        run(2'b01, 32'd7,         32'hFFFFFFFA, 5'd6,  32'hFFFFFFFF);
        run(2'b01, 32'h80000000,  32'h80000000, 5'd6,  32'h40000000);
        run(2'b00, 32'h80000000,  32'h80000000, 5'd7,  32'h00000000);
        run(2'b10, 32'hFFFFFFF9,  32'd2,        5'd8,  32'hFFFFFFFD);
        run(2'b11, 32'hFFFFFFF9,  32'd2,        5'd9,  32'hFFFFFFFF);
        run(2'b10, 32'd7,         32'hFFFFFFFE, 5'd10, 32'hFFFFFFFD);
        run(2'b11, 32'd7,         32'hFFFFFFFE, 5'd11, 32'h00000001);
        run(2'b10, 32'd100,       32'd0,        5'd12, 32'hFFFFFFFF);
        run(2'b11, 32'd100,       32'd0,        5'd13, 32'h00000064);
        run(2'b10, 32'h80000000,  32'hFFFFFFFF, 5'd14, 32'h80000000);
        run(2'b11, 32'h80000000,  32'hFFFFFFFF, 5'd15, 32'h00000000);
        run(2'b10, 32'd1000,      32'd7,        5'd16, 32'd142);
        run(2'b11, 32'd1000,      32'd7,        5'd17, 32'd6);
        run(2'b00, 32'd5,         32'd5,        5'd0,  32'd25);

        // Start pulsed while busy must be dropped
        issue(2'b00, 32'd2, 32'd3, 5'd20, 32'd6);
        repeat (5) @(negedge clk);
        start  = 1'b1;
        op     = 2'b10;
        rsData = 32'd100;
        rtData = 32'd5;
        rdIn   = 5'd21;
        @(negedge clk);
        start  = 1'b0;
        drain(32'd6);
        repeat (40) @(negedge clk);

        // Abort in the 10th CALC cycle
        @(negedge clk);
        start  = 1'b1;
        op     = 2'b00;
        rsData = 32'd1;
        rtData = 32'd1;
        rdIn   = 5'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("busy_before_abort", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_regWrite", 64'(regWrite), 64'd0);
        chk("abort_writeData", 64'(writeData), 64'd0);
        chk("abort_rd", 64'(rd), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (45) @(negedge clk);
        run(2'b00, 32'd3, 32'd3, 5'd4, 32'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
